// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
// Time-multiplexed scan controller for a 4-digit display. A prescaler sets
// how long each digit stays selected. A 2-bit select drives the downstream
// 2-to-4 digit decoder. The nibble shown for the selected digit comes from an
// active value register. New values are staged in a pending register, and
// move into the active register only at a frame boundary, or at once while
// scanning is disabled. This keeps any frame from mixing old and new digits.
//
// Ports
//   clk             system clock, rising-edge state updates
//   reset_n         asynchronous active-low reset
//   en              scan enable; low freezes prescaler and select
//   load            single-cycle request to capture value_in into pending
//   value_in[15:0]  display value, digit k = value_in[4k+3:4k]
//   blank_lz        enable leading-zero blanking
//   sel[1:0]        current digit index, to decoder input
//   nibble[3:0]     nibble of the active value selected by sel
//   blank           high = current digit must be dark
//   frame_done      one-cycle pulse when sel wraps 3 -> 0
//   update_pending  pending value not yet applied to the display

module digit_scan_ctrl #(
    parameter int unsigned DWELL = 50000,
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [3:0]  nibble,
    output logic        blank,
    output logic        frame_done,
    output logic        update_pending
);

    // Reject parameter sets the prescaler cannot honour.
    if (DWELL < 2) begin : gen_dwell_chk
        $error("digit_scan_ctrl: DWELL must be at least 2");
    end
    if (64'(DWELL) > (64'd1 << CNT_W)) begin : gen_cnt_w_chk
        $error("digit_scan_ctrl: CNT_W too narrow for DWELL");
    end

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(DWELL - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] prescale_q, prescale_d;
    logic [1:0]       sel_q, sel_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      pending_q, pending_d;
    logic [15:0]      active_q, active_d;
    logic             upd_q, upd_d;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic step;
    logic boundary;
    logic apply;

    // step is the last cycle of a dwell period. boundary is the last cycle
    // of the last digit, so the new frame starts on the following edge.
    assign step     = en && (prescale_q == LastCount);
    assign boundary = step && (sel_q == 2'd3);

    // Pending data may be applied at a boundary. It may also be applied
    // whenever scanning is frozen, because a frozen display cannot tear.
    assign apply = upd_q && (boundary || !en);

    always_comb begin
        prescale_d   = prescale_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;

        if (en) begin
            if (prescale_q == LastCount) begin
                prescale_d = '0;
            end else begin
                prescale_d = prescale_q + CNT_W'(1);
            end
        end

        if (step) begin
            sel_d = sel_q + 2'd1;
        end

        // Registered pulse, so it is high in the first cycle with sel back at 0.
        frame_done_d = boundary;
    end

    // ------------------------------------------------------------------
    // Shadow value registers
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        upd_d     = upd_q;

        // active reads pending_q before this edge's load lands. A load that
        // coincides with a boundary therefore waits for the next frame.
        if (apply) begin
            active_d = pending_q;
            upd_d    = 1'b0;
        end

        if (load) begin
            pending_d = value_in;
            upd_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q   <= '0;
            sel_q        <= 2'd0;
            frame_done_q <= 1'b0;
            pending_q    <= 16'h0000;
            active_q     <= 16'h0000;
            upd_q        <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            upd_q        <= upd_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit output and leading-zero blanking
    // ------------------------------------------------------------------
    // zero_from[k] is high when digit k and every more significant digit
    // are zero.
    logic [3:0] zero_from;

    always_comb begin
        zero_from    = 4'b0000;
        zero_from[3] = (active_q[15:12] == 4'h0);
        for (int k = 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (active_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        nibble = 4'h0;
        unique case (sel_q)
            2'd0: nibble = active_q[3:0];
            2'd1: nibble = active_q[7:4];
            2'd2: nibble = active_q[11:8];
            2'd3: nibble = active_q[15:12];
            default: nibble = 4'h0;
        endcase
    end

    // Digit 0 is never blanked, so a value of zero still shows one "0".
    assign blank          = blank_lz && (sel_q != 2'd0) && zero_from[sel_q];
    assign sel            = sel_q;
    assign frame_done     = frame_done_q;
    assign update_pending = upd_q;

endmodule
